uart_verici_kuyrugu: RTL and testbench
======================================

# uart_verici_kuyrugu

Transmit-side byte queue and launch controller sitting directly upstream of `uart_verici`. It accepts bytes from the peripheral bus write path into a synchronous FIFO. It launches one frame at a time into the transmitter via `basla_i`/`gelen_veri_gecerli_i`/`gelen_veri_i`, holds the byte stable for the whole frame, and waits for `bitti` before launching the next byte.

## Interface

Parameters:
- `DERINLIK`, 8: FIFO depth in bytes; power of two, at least 2.
- `SAYAC_BIT`, `$clog2(DERINLIK)+1`: width of the occupancy count.

Ports:
- `clk_i` input, 1: single clock for all logic.
- `rst_i` input, 1: synchronous, active-high reset.
- `yaz_gecerli_i` input, 1: bus write strobe; a byte is accepted when it is 1 and `yaz_hazir_o` is 1.
- `yaz_veri_i` input, 8: byte to enqueue.
- `yaz_hazir_o` output, 1: FIFO not full.
- `temizle_i` input, 1: flush the FIFO contents.
- `doluluk_o` output, SAYAC_BIT: bytes currently queued, excluding the byte in flight.
- `bos_o` output, 1: FIFO empty.
- `mesgul_o` output, 1: a frame is launched and `bitti` has not yet been received.
- `verici_basla_o` output, 1: drives `basla_i` of the transmitter.
- `verici_veri_gecerli_o` output, 1: drives `gelen_veri_gecerli_i`.
- `verici_veri_o` output, 8: drives `gelen_veri_i`.
- `verici_bitti_i` input, 1: `bitti` from the transmitter.

## Operation

- The FIFO uses write and read pointers of width `$clog2(DERINLIK)+1`, including a wrap bit.
- `doluluk_o` = write pointer − read pointer, computed modulo 2^SAYAC_BIT.
- Full is `doluluk_o == DERINLIK`. Empty is `doluluk_o == 0`.
- Write accept rule: `yaz_gecerli_i && yaz_hazir_o && !temizle_i`.
  - A write while full is dropped silently.
  - A pop in the same cycle does not make room for that write.
- FSM states and transitions:
  - BOSTA: if the FIFO is non-empty, pop the head into the holding register `veri_r` and go to GONDER.
  - GONDER: assert `verici_basla_o` and `verici_veri_gecerli_o` for exactly one cycle, then go to BEKLE.
  - BEKLE: `mesgul_o` = 1. Ignore everything until `verici_bitti_i` = 1, then go to ARA.
  - ARA: one idle cycle so the transmitter can return to its own idle state, then go to BOSTA.
- `verici_veri_o` = `veri_r` at all times.
  - `veri_r` changes only on the BOSTA→GONDER pop.
  - The byte is therefore stable from GONDER through ARA. This is required because the transmitter indexes `gelen_veri_i` bit by bit during the frame.
- `verici_bitti_i` is sampled only in BEKLE. Assertions in any other state are ignored.
- `temizle_i` behaviour:
  - Resets both pointers to 0 on the next edge.
  - A write in the same cycle is dropped.
  - It does not abort a frame already in GONDER/BEKLE/ARA; that frame completes normally.
- `mesgul_o` = 1 in GONDER, BEKLE and ARA.

## Timing

- Reset values, one edge after `rst_i` = 1:
  - State = BOSTA, pointers = 0, `veri_r` = 0x00.
  - `verici_basla_o` = 0, `verici_veri_gecerli_o` = 0, `verici_veri_o` = 0x00.
  - `mesgul_o` = 0, `bos_o` = 1, `doluluk_o` = 0, `yaz_hazir_o` = 1.
- Reset mid-frame returns to BOSTA with the queue emptied. The transmitter is reset by the same system reset.
- Launch latency from an idle, empty queue:
  - Write accepted in cycle t.
  - `bos_o` = 0 in t+1, and the pop happens at the end of t+1.
  - `verici_basla_o` = 1 in t+2.
- Back-to-back frames: `verici_bitti_i` in cycle b → ARA in b+1 → BOSTA pop in b+2 → next `verici_basla_o` in b+3.
- `doluluk_o` updates one edge after an accepted write or pop.
  - A simultaneous accept and pop leaves it unchanged.
- All outputs are registered or decoded directly from state and pointer registers. There are no input-to-output combinational paths.

## Structure

- `HIGH`/`LOW` come from `sabitler.vh`.
- The FSM state encoding stays in localparams local to this module; no other block needs it.
- One sub-module, `uart_fifo`: a parameterised synchronous FIFO with `DERINLIK` and data width 8.
  - Ports: push, pop, flush, data, full, empty, count.
  - It is reusable later by the receive path.
- The top level contains only the FSM, the `veri_r` holding register and the output decode.

## Test plan

- Reset, then write 0xA5 in cycle t → `verici_basla_o` and `verici_veri_gecerli_o` high for exactly one cycle at t+2 with `verici_veri_o` = 0xA5. `mesgul_o` stays 1 until ARA ends.
- Write 0x11, 0x22, 0x33 back to back; model `bitti` after 40 cycles per frame → three launches in order, each `bitti`→`basla` gap exactly 3 cycles, `verici_veri_o` constant during each frame.
- With DERINLIK = 8, write 10 bytes while the first frame is stalled in BEKLE:
  - The first byte is in flight; bytes 2–9 fill the queue, giving `doluluk_o` = 8 and `yaz_hazir_o` = 0.
  - Byte 10 is dropped; the transmitted sequence contains bytes 1–9 only.
- Pulse `verici_bitti_i` while in BOSTA and again in GONDER → no state change, no extra pop.
- Assert `temizle_i` during BEKLE with 5 bytes queued, together with a write → `doluluk_o` = 0 next cycle, the write is dropped, the in-flight frame completes, and no further launch occurs.
- Assert `rst_i` in BEKLE with 3 bytes queued → every output holds its reset value on the next edge, and no launch occurs until a new write.

Source files
------------

// File: rtl/uart_verici_kuyrugu_pkg.sv
// rtl/uart_verici_kuyrugu_pkg.sv - shared constants for the UART transmit queue
// Purpose: logic levels and byte width used by the transmit queue and its FIFO.
// Ports: none (package).
package uart_verici_kuyrugu_pkg;

    localparam logic HIGH     = 1'b1;
    localparam logic LOW      = 1'b0;
    localparam int   VERI_BIT = 8;

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - parameterised synchronous FIFO with occupancy count
// Purpose: byte queue with wrap-bit pointers; reusable by the receive path.
// Ports: clk_i, rst_i (sync, active-high), push_i, pop_i, flush_i,
//        veri_i (write data), veri_o (head data), dolu_o, bos_o, sayi_o (occupancy).
module uart_fifo
    import uart_verici_kuyrugu_pkg::*;
#(
    parameter int DERINLIK      = 8,
    parameter int VERI_GENISLIK = VERI_BIT,
    parameter int SAYAC_BIT     = $clog2(DERINLIK) + 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [VERI_GENISLIK-1:0] veri_i,
    output logic [VERI_GENISLIK-1:0] veri_o,
    output logic                     dolu_o,
    output logic                     bos_o,
    output logic [SAYAC_BIT-1:0]     sayi_o
);

    localparam int AW = $clog2(DERINLIK);

    logic [SAYAC_BIT-1:0]     r_yaz_ptr;
    logic [SAYAC_BIT-1:0]     r_oku_ptr;
    logic [VERI_GENISLIK-1:0] r_mem [DERINLIK];

    logic [SAYAC_BIT-1:0] w_sayi;
    logic                 w_dolu;
    logic                 w_bos;
    logic                 w_push_ok;
    logic                 w_pop_ok;

    // Wrap bit makes full/empty distinguishable with equal low pointer bits.
    assign w_sayi    = r_yaz_ptr - r_oku_ptr;
    assign w_dolu    = (w_sayi == SAYAC_BIT'(DERINLIK));
    assign w_bos     = (w_sayi == '0);
    // Fullness is judged before any same-cycle pop, so a pop never makes room.
    assign w_push_ok = push_i && !w_dolu && !flush_i;
    assign w_pop_ok  = pop_i && !w_bos && !flush_i;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_yaz_ptr <= '0;
            r_oku_ptr <= '0;
        end else begin
            if (w_push_ok) r_yaz_ptr <= r_yaz_ptr + 1'b1;
            if (w_pop_ok)  r_oku_ptr <= r_oku_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push_ok && !rst_i) begin
            r_mem[r_yaz_ptr[AW-1:0]] <= veri_i;
        end
    end

    assign veri_o = r_mem[r_oku_ptr[AW-1:0]];
    assign dolu_o = w_dolu;
    assign bos_o  = w_bos;
    assign sayi_o = w_sayi;

endmodule

// File: rtl/uart_verici_kuyrugu.sv
// rtl/uart_verici_kuyrugu.sv - transmit byte queue and frame launch controller
// Purpose: queues bus-written bytes and launches them one frame at a time into
//          the UART transmitter, holding the byte stable until bitti.
// Ports: clk_i, rst_i (sync, active-high); yaz_gecerli_i/yaz_veri_i/yaz_hazir_o
//        write path; temizle_i flush; doluluk_o, bos_o, mesgul_o status;
//        verici_basla_o, verici_veri_gecerli_o, verici_veri_o, verici_bitti_i
//        transmitter handshake.
module uart_verici_kuyrugu
    import uart_verici_kuyrugu_pkg::*;
#(
    parameter int DERINLIK  = 8,
    parameter int SAYAC_BIT = $clog2(DERINLIK) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 yaz_gecerli_i,
    input  logic [7:0]           yaz_veri_i,
    output logic                 yaz_hazir_o,
    input  logic                 temizle_i,
    output logic [SAYAC_BIT-1:0] doluluk_o,
    output logic                 bos_o,
    output logic                 mesgul_o,
    output logic                 verici_basla_o,
    output logic                 verici_veri_gecerli_o,
    output logic [7:0]           verici_veri_o,
    input  logic                 verici_bitti_i
);

    localparam logic [1:0] BOSTA  = 2'd0;
    localparam logic [1:0] GONDER = 2'd1;
    localparam logic [1:0] BEKLE  = 2'd2;
    localparam logic [1:0] ARA    = 2'd3;

    logic [1:0] r_durum;
    logic [1:0] w_sonraki;
    logic [7:0] veri_r;

    logic       w_fifo_dolu;
    logic       w_fifo_bos;
    logic [7:0] w_fifo_veri;
    logic       w_pop;
    logic       w_basla;
    logic       w_mesgul;

    uart_fifo #(
        .DERINLIK      (DERINLIK),
        .VERI_GENISLIK (8),
        .SAYAC_BIT     (SAYAC_BIT)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (yaz_gecerli_i),
        .pop_i   (w_pop),
        .flush_i (temizle_i),
        .veri_i  (yaz_veri_i),
        .veri_o  (w_fifo_veri),
        .dolu_o  (w_fifo_dolu),
        .bos_o   (w_fifo_bos),
        .sayi_o  (doluluk_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) r_durum <= BOSTA;
        else       r_durum <= w_sonraki;
    end

    // A flushing cycle does not pop: the head byte is being discarded.
    assign w_pop = (r_durum == BOSTA) && !w_fifo_bos && !temizle_i;

    always_comb begin
        w_sonraki = r_durum;
        case (r_durum)
            BOSTA:  if (w_pop) w_sonraki = GONDER;
            GONDER: w_sonraki = BEKLE;
            BEKLE:  if (verici_bitti_i) w_sonraki = ARA;
            ARA:    w_sonraki = BOSTA;
            default: w_sonraki = BOSTA;
        endcase
    end

    always_comb begin
        w_basla  = LOW;
        w_mesgul = HIGH;
        case (r_durum)
            BOSTA:   w_mesgul = LOW;
            GONDER:  w_basla  = HIGH;
            default: w_basla  = LOW;
        endcase
    end

    // Only the launch pop updates the holding register; the transmitter reads
    // it bit by bit for the whole frame.
    always_ff @(posedge clk_i) begin
        if (rst_i)      veri_r <= 8'h00;
        else if (w_pop) veri_r <= w_fifo_veri;
    end

    assign verici_basla_o        = w_basla;
    assign verici_veri_gecerli_o = w_basla;
    assign verici_veri_o         = veri_r;
    assign mesgul_o              = w_mesgul;
    assign bos_o                 = w_fifo_bos;
    assign yaz_hazir_o           = !w_fifo_dolu;

endmodule

// File: tb/tb_uart_verici_kuyrugu.sv
// tb/tb_uart_verici_kuyrugu.sv - directed self-checking bench for uart_verici_kuyrugu
module tb_uart_verici_kuyrugu;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       yaz_gecerli_i = 1'b0;
    logic [7:0] yaz_veri_i = 8'h00;
    logic       yaz_hazir_o;
    logic       temizle_i = 1'b0;
    logic [3:0] doluluk_o;
    logic       bos_o;
    logic       mesgul_o;
    logic       verici_basla_o;
    logic       verici_veri_gecerli_o;
    logic [7:0] verici_veri_o;
    logic       verici_bitti_i = 1'b0;

    uart_verici_kuyrugu #(.DERINLIK(8)) dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .yaz_gecerli_i         (yaz_gecerli_i),
        .yaz_veri_i            (yaz_veri_i),
        .yaz_hazir_o           (yaz_hazir_o),
        .temizle_i             (temizle_i),
        .doluluk_o             (doluluk_o),
        .bos_o                 (bos_o),
        .mesgul_o              (mesgul_o),
        .verici_basla_o        (verici_basla_o),
        .verici_veri_gecerli_o (verici_veri_gecerli_o),
        .verici_veri_o         (verici_veri_o),
        .verici_bitti_i        (verici_bitti_i)
    );

    always #5 clk_i = ~clk_i;

    int         cyc = 0;
    int         n_total = 0;
    int         n_bad = 0;
    int         stab_err = 0;
    logic [7:0] q_tx[$];
    int         q_cyc[$];
    logic [7:0] cur_byte = 8'h00;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Transmitter-side monitor: records each launch and watches byte stability.
    always @(negedge clk_i) begin
        if (verici_basla_o) begin
            q_tx.push_back(verici_veri_o);
            q_cyc.push_back(cyc);
            cur_byte = verici_veri_o;
        end else if (mesgul_o && (verici_veri_o != cur_byte)) begin
            stab_err++;
        end
    end

    task automatic kontrol(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic yaz(input logic [7:0] b);
        yaz_gecerli_i = 1'b1;
        yaz_veri_i    = b;
        tick();
        yaz_gecerli_i = 1'b0;
    endtask

    task automatic bitti_ver(output int b);
        b = cyc;
        verici_bitti_i = 1'b1;
        tick();
        verici_bitti_i = 1'b0;
    endtask

    // Waits for launch number k, lets the frame run for gecikme cycles, then ends it.
    task automatic frame_tamamla(input int k, input int gecikme, output int b);
        int n;
        n = 0;
        while (q_tx.size() <= k && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) kontrol("launch_timeout", 32'd0, 32'd1);
        repeat (gecikme) tick();
        bitti_ver(b);
    endtask

    task automatic reset_kontrol(input string tag);
        kontrol({tag, "_basla"},   32'(verici_basla_o), 32'd0);
        kontrol({tag, "_gecerli"}, 32'(verici_veri_gecerli_o), 32'd0);
        kontrol({tag, "_veri"},    32'(verici_veri_o), 32'h00);
        kontrol({tag, "_mesgul"},  32'(mesgul_o), 32'd0);
        kontrol({tag, "_bos"},     32'(bos_o), 32'd1);
        kontrol({tag, "_doluluk"}, 32'(doluluk_o), 32'd0);
        kontrol({tag, "_hazir"},   32'(yaz_hazir_o), 32'd1);
    endtask

    logic [7:0] exp3 [3];
    int b;

    initial begin
        // Reset
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        reset_kontrol("rst");

        // Single byte latency and one-cycle launch
        q_tx.delete(); q_cyc.delete();
        yaz(8'hA5);
        kontrol("t1_bos", 32'(bos_o), 32'd0);
        kontrol("t1_basla_early", 32'(verici_basla_o), 32'd0);
        kontrol("t1_doluluk", 32'(doluluk_o), 32'd1);
        tick();
        kontrol("t1_basla", 32'(verici_basla_o), 32'd1);
        kontrol("t1_gecerli", 32'(verici_veri_gecerli_o), 32'd1);
        kontrol("t1_veri", 32'(verici_veri_o), 32'hA5);
        kontrol("t1_mesgul", 32'(mesgul_o), 32'd1);
        tick();
        kontrol("t1_basla_off", 32'(verici_basla_o), 32'd0);
        kontrol("t1_gecerli_off", 32'(verici_veri_gecerli_o), 32'd0);
        repeat (5) tick();
        kontrol("t1_mesgul_bekle", 32'(mesgul_o), 32'd1);
        bitti_ver(b);
        kontrol("t1_mesgul_ara", 32'(mesgul_o), 32'd1);
        tick();
        kontrol("t1_mesgul_bosta", 32'(mesgul_o), 32'd0);
        kontrol("t1_veri_hold", 32'(verici_veri_o), 32'hA5);
        kontrol("t1_launches", 32'(q_tx.size()), 32'd1);

        // Back-to-back frames with 40-cycle transmitter
        q_tx.delete(); q_cyc.delete();
        exp3[0] = 8'h11; exp3[1] = 8'h22; exp3[2] = 8'h33;
        yaz(8'h11);
        yaz(8'h22);
        yaz(8'h33);
        for (int k = 0; k < 3; k++) begin
            int bprev;
            bprev = b;
            frame_tamamla(k, 40, b);
            kontrol($sformatf("t2_veri%0d", k), 32'(q_tx[k]), 32'(exp3[k]));
            if (k > 0) kontrol($sformatf("t2_gap%0d", k), 32'(q_cyc[k] - bprev), 32'd3);
        end
        repeat (5) tick();
        kontrol("t2_launches", 32'(q_tx.size()), 32'd3);
        kontrol("t2_bos", 32'(bos_o), 32'd1);

        // Fill while stalled: 10 writes, 9 transmitted
        q_tx.delete(); q_cyc.delete();
        for (int i = 1; i <= 10; i++) yaz(8'hB0 + 8'(i));
        kontrol("t3_doluluk", 32'(doluluk_o), 32'd8);
        kontrol("t3_hazir", 32'(yaz_hazir_o), 32'd0);
        for (int k = 0; k < 9; k++) frame_tamamla(k, 2, b);
        repeat (10) tick();
        kontrol("t3_launches", 32'(q_tx.size()), 32'd9);
        for (int k = 0; k < 9; k++) begin
            if (k < q_tx.size()) kontrol($sformatf("t3_veri%0d", k), 32'(q_tx[k]), 32'hB1 + 32'(k));
        end
        kontrol("t3_bos", 32'(bos_o), 32'd1);

        // bitti outside BEKLE is ignored
        q_tx.delete(); q_cyc.delete();
        bitti_ver(b);
        kontrol("t4_idle_mesgul", 32'(mesgul_o), 32'd0);
        kontrol("t4_idle_bos", 32'(bos_o), 32'd1);
        yaz(8'h5C);
        verici_bitti_i = 1'b1;
        tick();
        kontrol("t4_basla", 32'(verici_basla_o), 32'd1);
        kontrol("t4_veri", 32'(verici_veri_o), 32'h5C);
        tick();
        verici_bitti_i = 1'b0;
        repeat (5) tick();
        kontrol("t4_still_bekle", 32'(mesgul_o), 32'd1);
        bitti_ver(b);
        repeat (5) tick();
        kontrol("t4_launches", 32'(q_tx.size()), 32'd1);
        kontrol("t4_doluluk", 32'(doluluk_o), 32'd0);

        // Flush during BEKLE with 5 queued plus a simultaneous write
        q_tx.delete(); q_cyc.delete();
        for (int i = 0; i < 6; i++) yaz(8'h70 + 8'(i));
        kontrol("t5_doluluk_pre", 32'(doluluk_o), 32'd5);
        temizle_i = 1'b1;
        yaz_gecerli_i = 1'b1;
        yaz_veri_i = 8'h76;
        tick();
        temizle_i = 1'b0;
        yaz_gecerli_i = 1'b0;
        kontrol("t5_doluluk", 32'(doluluk_o), 32'd0);
        kontrol("t5_bos", 32'(bos_o), 32'd1);
        kontrol("t5_mesgul", 32'(mesgul_o), 32'd1);
        bitti_ver(b);
        repeat (10) tick();
        kontrol("t5_launches", 32'(q_tx.size()), 32'd1);
        kontrol("t5_mesgul_end", 32'(mesgul_o), 32'd0);
        kontrol("t5_veri", 32'(verici_veri_o), 32'h70);

        // Reset in BEKLE with 3 queued
        q_tx.delete(); q_cyc.delete();
        for (int i = 0; i < 4; i++) yaz(8'h80 + 8'(i));
        kontrol("t6_doluluk_pre", 32'(doluluk_o), 32'd3);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        reset_kontrol("t6");
        repeat (10) tick();
        kontrol("t6_launches", 32'(q_tx.size()), 32'd1);
        yaz(8'h90);
        tick();
        kontrol("t6_basla", 32'(verici_basla_o), 32'd1);
        kontrol("t6_veri", 32'(verici_veri_o), 32'h90);

        kontrol("stability", 32'(stab_err), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
